// File: rtl/gpu_mem_port_arbiter_pkg.sv
// Shared definitions for the GPU memory port arbiter: requester ids,
// FSM encodings and the round-robin pointer advance helper.
package gpu_mem_port_arbiter_pkg;

    typedef logic [1:0] req_id_t;
    typedef logic [1:0] arb_state_t;

    localparam req_id_t REQ_PW  = 2'd0;
    localparam req_id_t REQ_PR  = 2'd1;
    localparam req_id_t REQ_LCD = 2'd2;

    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_ACCESS  = 2'd1;
    localparam arb_state_t ST_RD_WAIT = 2'd2;
    localparam arb_state_t ST_RESP    = 2'd3;

    // Id after the given one, wrapping LCD (and the unused code 3) back to PW.
    function automatic req_id_t rr_next(input req_id_t id);
        return (id >= REQ_LCD) ? REQ_PW : req_id_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/gpu_mem_port_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin arbiter with an LCD urgent override.
// The priority pointer is owned by the parent; ptr names the highest-priority id.
module rr_arbiter3
    import gpu_mem_port_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic       urgent,
    input  req_id_t    ptr,
    output logic [2:0] grant,
    output req_id_t    grant_id
);

    req_id_t cand0;
    req_id_t cand1;
    req_id_t cand2;

    always_comb begin
        cand0    = (ptr > REQ_LCD) ? REQ_PW : ptr;
        cand1    = rr_next(cand0);
        cand2    = rr_next(cand1);
        grant_id = REQ_PW;
        grant    = 3'b000;
        if (urgent && req[REQ_LCD]) begin
            grant_id = REQ_LCD;
        end else if (req[cand0]) begin
            grant_id = cand0;
        end else if (req[cand1]) begin
            grant_id = cand1;
        end else if (req[cand2]) begin
            grant_id = cand2;
        end
        if (req != 3'b000) begin
            grant = 3'b001 << grant_id;
        end
    end

endmodule

// File: rtl/gpu_mem_port_arbiter.sv
// Shares the single GPU memory port between PCIe write, PCIe read and LCD
// scanout; one access at a time, round-robin with an LCD urgent override.
module gpu_mem_port_arbiter
    import gpu_mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pw_req,
    input  logic [ADDR_W-1:0]   pw_addr,
    input  logic [DATA_W-1:0]   pw_wdata,
    input  logic [DATA_W/8-1:0] pw_be,
    output logic                pw_ack,
    input  logic                pr_req,
    input  logic [ADDR_W-1:0]   pr_addr,
    output logic                pr_ack,
    input  logic                lcd_req,
    input  logic [ADDR_W-1:0]   lcd_addr,
    input  logic                lcd_urgent,
    output logic                lcd_ack,
    output logic [DATA_W-1:0]   rd_data,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    req_id_t             win_q, win_d;
    req_id_t             ptr_q, ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [2:0]          req_vec;
    logic [2:0]          grant;
    req_id_t             grant_id;
    logic                in_access;
    logic                win_is_wr;

    assign req_vec = {lcd_req, pr_req, pw_req};

    rr_arbiter3 u_arb (
        .req      (req_vec),
        .urgent   (lcd_urgent),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 3'b000) begin
                    state_d = ST_ACCESS;
                    win_d   = grant_id;
                    ptr_d   = rr_next(grant_id);
                    wdata_d = pw_wdata;
                    be_d    = pw_be;
                    case (grant_id)
                        REQ_PW:  addr_d = pw_addr;
                        REQ_PR:  addr_d = pr_addr;
                        default: addr_d = lcd_addr;
                    endcase
                end
            end
            ST_ACCESS: begin
                if (win_q == REQ_PW) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = 3'(RD_LAT - 1);
                end
            end
            // The last wait cycle is the one in which memory presents the read word.
            ST_RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rd_data_d = mem_rdata;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_q     <= REQ_PW;
            ptr_q     <= REQ_PW;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign in_access = (state_q == ST_ACCESS);
    assign win_is_wr = (win_q == REQ_PW);

    assign mem_en    = in_access;
    assign mem_we    = in_access && win_is_wr;
    assign mem_be    = in_access ? (win_is_wr ? be_q : {BE_W{1'b1}}) : '0;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = (in_access && win_is_wr) ? wdata_q : '0;
    assign pw_ack    = in_access && win_is_wr;
    assign pr_ack    = (state_q == ST_RESP) && (win_q == REQ_PR);
    assign lcd_ack   = (state_q == ST_RESP) && (win_q == REQ_LCD);
    assign rd_data   = rd_data_q;
    assign busy      = (state_q != ST_IDLE);

    // A granted requester must hold its request until it has been acknowledged.
    req_held_until_ack: assert property (@(posedge clk) disable iff (rst)
        (state_q != ST_IDLE) |-> req_vec[win_q]);

endmodule

// File: tb/tb_gpu_mem_port_arbiter.sv
// Scoreboard bench for gpu_mem_port_arbiter: one instance with RD_LAT=4 driven by
// three requester agents, plus an RD_LAT=1 instance for the single-read latency case.
module tb_gpu_mem_port_arbiter;
    import gpu_mem_port_arbiter_pkg::*;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        pw_req = 1'b0;
    logic [15:0] pw_addr = '0;
    logic [31:0] pw_wdata = '0;
    logic [3:0]  pw_be = '0;
    logic        pw_ack;
    logic        pr_req = 1'b0;
    logic [15:0] pr_addr = '0;
    logic        pr_ack;
    logic        lcd_req = 1'b0;
    logic [15:0] lcd_addr = '0;
    logic        lcd_urgent = 1'b0;
    logic        lcd_ack;
    logic [31:0] rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic        b_pr_req = 1'b0;
    logic [15:0] b_pr_addr = '0;
    logic        b_pw_ack, b_pr_ack, b_lcd_ack;
    logic [31:0] b_rd_data;
    logic        b_mem_en, b_mem_we;
    logic [3:0]  b_mem_be;
    logic [15:0] b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [31:0] b_mem_rdata;
    logic        b_busy;

    txn_t        expQ[$];
    txn_t        pwQ[$];
    txn_t        prQ[$];
    txn_t        lcdQ[$];
    int          ackCycleQ[$];
    int          cyc = 0;
    int          memEnCount = 0;
    int          checkCount = 0;
    int          passCount = 0;
    logic [2:0]  monAck;
    txn_t        monTxn;
    logic [31:0] rdPipe [0:LAT_A-1];
    logic [31:0] bRd;

    always #5 clk = ~clk;

    gpu_mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(LAT_A)) dut (
        .clk(clk), .rst(rst),
        .pw_req(pw_req), .pw_addr(pw_addr), .pw_wdata(pw_wdata), .pw_be(pw_be), .pw_ack(pw_ack),
        .pr_req(pr_req), .pr_addr(pr_addr), .pr_ack(pr_ack),
        .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_urgent(lcd_urgent), .lcd_ack(lcd_ack),
        .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    gpu_mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(LAT_B)) dutB (
        .clk(clk), .rst(rst),
        .pw_req(1'b0), .pw_addr(16'h0), .pw_wdata(32'h0), .pw_be(4'h0), .pw_ack(b_pw_ack),
        .pr_req(b_pr_req), .pr_addr(b_pr_addr), .pr_ack(b_pr_ack),
        .lcd_req(1'b0), .lcd_addr(16'h0), .lcd_urgent(1'b0), .lcd_ack(b_lcd_ack),
        .rd_data(b_rd_data), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] memFunc(input logic [15:0] a);
        if (a == 16'h0020) return 32'h12345678;
        return {~a, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: actual 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    // Queue a request on its agent and record the expected outcome; call order is grant order.
    task automatic applyStimulus(input logic [1:0] id, input logic [15:0] addr,
                                 input logic [31:0] data, input logic [3:0] be);
        txn_t t;
        t.id   = id;
        t.addr = addr;
        t.be   = be;
        t.data = (id == REQ_PW) ? data : memFunc(addr);
        expQ.push_back(t);
        case (id)
            REQ_PW:  pwQ.push_back(t);
            REQ_PR:  prQ.push_back(t);
            default: lcdQ.push_back(t);
        endcase
    endtask

    task automatic waitDrain(input string tag, input int maxCycles);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(expQ.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: the main instance returns words LAT_A cycles after mem_en, the second after one.
    always @(posedge clk) begin
        rdPipe[0] <= (mem_en && !mem_we) ? memFunc(mem_addr) : 32'hBAD0BAD0;
        for (int i = 1; i < LAT_A; i++) rdPipe[i] <= rdPipe[i-1];
        bRd <= (b_mem_en && !b_mem_we) ? memFunc(b_mem_addr) : 32'hBAD0BAD0;
    end
    assign mem_rdata   = rdPipe[LAT_A-1];
    assign b_mem_rdata = bRd;

    // Requester agents hold req with the head item until its ack has been seen.
    always @(posedge clk) begin
        #1;
        pw_req = (pwQ.size() != 0);
        if (pw_req) begin
            pw_addr  = pwQ[0].addr;
            pw_wdata = pwQ[0].data;
            pw_be    = pwQ[0].be;
        end
        pr_req = (prQ.size() != 0);
        if (pr_req) pr_addr = prQ[0].addr;
        lcd_req = (lcdQ.size() != 0);
        if (lcd_req) lcd_addr = lcdQ[0].addr;
    end

    // Monitor: checks each memory access against the head expectation and retires it on its ack.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                memEnCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_mem_en", 32'(mem_en), 32'd0);
                end else begin
                    monTxn = expQ[0];
                    checkOutput("mem_we", 32'(mem_we), 32'(monTxn.id == REQ_PW));
                    checkOutput("mem_addr", 32'(mem_addr), 32'(monTxn.addr));
                    if (monTxn.id == REQ_PW) begin
                        checkOutput("mem_wdata", mem_wdata, monTxn.data);
                        checkOutput("mem_be_wr", 32'(mem_be), 32'(monTxn.be));
                    end else begin
                        checkOutput("mem_be_rd", 32'(mem_be), 32'hF);
                    end
                end
            end
            monAck = {lcd_ack, pr_ack, pw_ack};
            if (monAck != 3'b000) begin
                ackCycleQ.push_back(cyc);
                checkOutput("ack_onehot", 32'($countones(monAck)), 32'd1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(monAck), 32'd0);
                end else begin
                    monTxn = expQ.pop_front();
                    checkOutput("ack_id", 32'(monAck), 32'(3'b001 << monTxn.id));
                    if (monTxn.id != REQ_PW) checkOutput("rd_data", rd_data, monTxn.data);
                end
                if (monAck[0] && pwQ.size() != 0) void'(pwQ.pop_front());
                if (monAck[1] && prQ.size() != 0) void'(prQ.pop_front());
                if (monAck[2] && lcdQ.size() != 0) void'(lcdQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int n;
        logic seenOther;
        logic [15:0] bAddr;
        logic [3:0] bBe;

        repeat (3) @(negedge clk);
        checkOutput("rst_outputs", 32'({busy, mem_en, mem_we, pw_ack, pr_ack, lcd_ack}), 32'd0);
        checkOutput("rst_rd_data", rd_data, 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);

        // All three requesters pending as reset releases: pw, pr, lcd, pw, pr, lcd.
        applyStimulus(REQ_PW,  16'h0100, 32'h11110000, 4'hF);
        applyStimulus(REQ_PR,  16'h0200, 32'h0, 4'hF);
        applyStimulus(REQ_LCD, 16'h0300, 32'h0, 4'hF);
        applyStimulus(REQ_PW,  16'h0101, 32'h22220000, 4'hA);
        applyStimulus(REQ_PR,  16'h0201, 32'h0, 4'hF);
        applyStimulus(REQ_LCD, 16'h0301, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitDrain("t3_drain", 100);

        // Single write and its ack latency.
        ackCycleQ.delete();
        memEnCount = 0;
        @(negedge clk);
        t0 = cyc;
        applyStimulus(REQ_PW, 16'h0010, 32'hDEADBEEF, 4'hF);
        waitDrain("t1_drain", 20);
        checkOutput("t1_ack_count", 32'(ackCycleQ.size()), 32'd1);
        if (ackCycleQ.size() != 0) checkOutput("t1_latency", 32'(ackCycleQ[0] - t0), 32'd2);
        checkOutput("t1_mem_en_count", 32'(memEnCount), 32'd1);

        // RD_LAT=1 instance: pr read of 0x0020, ack three cycles after IDLE samples it.
        @(negedge clk);
        t0 = cyc;
        b_pr_addr = 16'h0020;
        b_pr_req  = 1'b1;
        seenOther = 1'b0;
        bAddr = '0;
        bBe = '0;
        n = 0;
        while (!b_pr_ack && n < 20) begin
            @(negedge clk);
            n++;
            seenOther = seenOther | b_lcd_ack | b_pw_ack | b_mem_we;
            if (b_mem_en) begin
                bAddr = b_mem_addr;
                bBe   = b_mem_be;
            end
        end
        checkOutput("t2_pr_ack", 32'(b_pr_ack), 32'd1);
        checkOutput("t2_latency", 32'(cyc - t0), 32'd3);
        checkOutput("t2_rd_data", b_rd_data, 32'h12345678);
        checkOutput("t2_other_acks", 32'(seenOther), 32'd0);
        checkOutput("t2_mem_addr", 32'(bAddr), 32'h0020);
        checkOutput("t2_mem_be", 32'(bBe), 32'hF);
        checkOutput("t2_busy", 32'(b_busy), 32'd1);
        @(posedge clk);
        #1 b_pr_req = 1'b0;

        // Urgent LCD jumps ahead of pending pw/pr; the pointer then restarts at pw.
        @(negedge clk);
        lcd_urgent = 1'b1;
        applyStimulus(REQ_LCD, 16'h0400, 32'h0, 4'hF);
        applyStimulus(REQ_PW,  16'h0401, 32'hCAFEF00D, 4'h3);
        applyStimulus(REQ_PR,  16'h0402, 32'h0, 4'hF);
        waitDrain("t4_drain", 60);
        lcd_urgent = 1'b0;

        // Reset in the middle of a RD_LAT=4 read; the still-pending LCD request is served afterwards.
        @(negedge clk);
        applyStimulus(REQ_LCD, 16'h0040, 32'h0, 4'hF);
        n = 0;
        while (!(mem_en && !mem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_read_issued", 32'(mem_en), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_outputs", 32'({busy, mem_en, mem_we, pw_ack, pr_ack, lcd_ack}), 32'd0);
        checkOutput("t5_rst_rd_data", rd_data, 32'd0);
        seenOther = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seenOther = seenOther | pw_ack | pr_ack | lcd_ack | mem_en;
        end
        checkOutput("t5_quiet_in_reset", 32'(seenOther), 32'd0);
        rst = 1'b0;
        waitDrain("t5_drain", 40);
        checkOutput("t5_rd_data_after", rd_data, memFunc(16'h0040));

        // Back-to-back writes from a single requester: one ack every two cycles.
        ackCycleQ.delete();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(REQ_PW, 16'(16'h0500 + i), $urandom, 4'(1 << i));
        end
        waitDrain("t6_drain", 40);
        checkOutput("t6_ack_count", 32'(ackCycleQ.size()), 32'd4);
        for (int i = 1; i < ackCycleQ.size(); i++) begin
            checkOutput($sformatf("t6_gap%0d", i), 32'(ackCycleQ[i] - ackCycleQ[i-1]), 32'd2);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
